// File: rtl/boot_loader.sv
// Boot loader: receives a framed boot image over a byte stream, writes the
// payload words into instruction memory, verifies an XOR checksum and then
// either releases the CPU at the image entry point or holds it in error.
module boot_loader #(
  parameter logic [7:0]  MAGIC     = 8'hA5,
  parameter int          MAX_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [63:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic [63:0] boot_pc,
  output logic        done,
  output logic        error
);

  localparam int          KW   = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [31:0] MAXW = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_ENTRY, S_DATA, S_CSUM, S_RUN, S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [15:0]     len_q, len_d;
  logic [31:0]     entry_q, entry_d;
  logic [31:0]     word_q, word_d;
  logic [7:0]      csum_q, csum_d;
  logic [KW-1:0]   k_q, k_d;
  logic            wr_evt;

  logic            rx_ready_q, rx_ready_d;
  logic            imem_we_q, imem_we_d;
  logic [63:0]     imem_addr_q, imem_addr_d;
  logic [31:0]     imem_wdata_q, imem_wdata_d;
  logic            cpu_reset_q, cpu_reset_d;
  logic [63:0]     boot_pc_q, boot_pc_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic            xfer;

  // A byte moves only on a valid/ready handshake; ready is the registered flag.
  assign xfer = rx_valid & rx_ready_q;

  // State register plus parse datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      entry_q      <= '0;
      word_q       <= '0;
      csum_q       <= '0;
      k_q          <= '0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      boot_pc_q    <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      entry_q      <= entry_d;
      word_q       <= word_d;
      csum_q       <= csum_d;
      k_q          <= k_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      boot_pc_q    <= boot_pc_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  // Next-state logic: field byte counting, little-endian assembly, checksum.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    entry_d = entry_q;
    word_d  = word_q;
    csum_d  = csum_q;
    k_d     = k_q;
    wr_evt  = 1'b0;
    if (xfer) begin
      unique case (state_q)
        S_IDLE: begin
          // Anything but the sync byte is silently dropped.
          if (rx_data == MAGIC) begin
            state_d = S_LEN;
            cnt_d   = '0;
            csum_d  = '0;
          end
        end
        S_LEN: begin
          csum_d = csum_q ^ rx_data;
          len_d  = {rx_data, len_q[15:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd1) begin
            cnt_d = '0;
            if (len_d == 16'd0 || {16'd0, len_d} > MAXW) state_d = S_ERR;
            else                                           state_d = S_ENTRY;
          end
        end
        S_ENTRY: begin
          csum_d  = csum_q ^ rx_data;
          entry_d = {rx_data, entry_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            k_d = '0;
            if (entry_d >= {16'd0, len_q}) state_d = S_ERR;
            else                           state_d = S_DATA;
          end
        end
        S_DATA: begin
          csum_d = csum_q ^ rx_data;
          word_d = {rx_data, word_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            wr_evt = 1'b1;
            if (32'(k_q) == {16'd0, len_q} - 32'd1) state_d = S_CSUM;
            else                                     k_d     = k_q + KW'(1);
          end
        end
        S_CSUM: begin
          if (rx_data == csum_q) state_d = S_RUN;
          else                   state_d = S_ERR;
        end
        default: ;
      endcase
    end
  end

  // Output logic: registered outputs derived from the upcoming state and write event.
  always_comb begin
    rx_ready_d   = (state_d != S_RUN) && (state_d != S_ERR);
    imem_we_d    = wr_evt;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    if (wr_evt) begin
      // Address uses the index of the word just completed, before any increment.
      imem_addr_d  = BASE_ADDR + (64'(k_q) << 2);
      imem_wdata_d = word_d;
    end
    cpu_reset_d = (state_d != S_RUN);
    done_d      = (state_d == S_RUN);
    error_d     = (state_d == S_ERR);
    boot_pc_d   = boot_pc_q;
    if (state_d == S_RUN && state_q != S_RUN)
      boot_pc_d = BASE_ADDR + ({32'd0, entry_q} << 2);
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign boot_pc    = boot_pc_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed testbench for boot_loader: nominal load, checksum error, garbage
// prefix, length/entry rejection, random stalls and reset mid-image.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        imem_we;
  logic [63:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic [63:0] boot_pc;
  logic        done;
  logic        error;

  int n_chk = 0;
  int n_err = 0;

  // Write log: single writer, tests measure relative to a snapshot of wtot.
  int          wtot = 0;
  logic [63:0] wa [64];
  logic [31:0] wd [64];

  // XOR of 02 00 01 00 00 00 11 22 33 44 55 66 77 88 = 0x8B
  localparam logic [7:0] CSUM_OK = 8'h8B;
  logic [7:0] img [14];

  boot_loader #(.MAGIC(8'hA5), .MAX_WORDS(1024), .BASE_ADDR(64'h0)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .boot_pc(boot_pc),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset && imem_we) begin
      wa[wtot % 64] = imem_addr;
      wd[wtot % 64] = imem_wdata;
      wtot = wtot + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int guard;
    if (stall) begin
      while ($urandom_range(0, 1) == 0) begin
        rx_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    guard = 0;
    while (!rx_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) chk("rdy_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_img(input logic [7:0] cs, input bit stall);
    for (int i = 0; i < 14; i++) send_byte(img[i], stall);
    send_byte(cs, stall);
  endtask

  task automatic apply_reset();
    #2 reset = 1'b0;
    #3;
    chk("rst_rx_ready", 64'(rx_ready), 64'd0);
    chk("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("rst_we", 64'(imem_we), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_rx_ready_rise", 64'(rx_ready), 64'd1);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_nominal(input string t, input int base);
    chk({t, "_nwr"}, 64'(wtot - base), 64'd2);
    chk({t, "_a0"}, wa[base % 64], 64'h0);
    chk({t, "_d0"}, 64'(wd[base % 64]), 64'h44332211);
    chk({t, "_a1"}, wa[(base + 1) % 64], 64'h4);
    chk({t, "_d1"}, 64'(wd[(base + 1) % 64]), 64'h88776655);
    chk({t, "_done"}, 64'(done), 64'd1);
    chk({t, "_err"}, 64'(error), 64'd0);
    chk({t, "_cpurst"}, 64'(cpu_reset), 64'd0);
    chk({t, "_pc"}, boot_pc, 64'h4);
    chk({t, "_rdy"}, 64'(rx_ready), 64'd0);
  endtask

  task automatic check_reject(input string t, input int base);
    chk({t, "_err"}, 64'(error), 64'd1);
    chk({t, "_done"}, 64'(done), 64'd0);
    chk({t, "_cpurst"}, 64'(cpu_reset), 64'd1);
    chk({t, "_rdy"}, 64'(rx_ready), 64'd0);
    wait_cycles(3);
    chk({t, "_nwr"}, 64'(wtot - base), 64'd0);
  endtask

  initial begin
    int base;
    img = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
            8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    // Last data byte is appended separately so the checksum byte can vary.
    // img holds MAGIC..0x77; 0x88 is sent via the extended stream below.

    // Nominal image
    apply_reset();
    base = wtot;
    for (int i = 0; i < 14; i++) send_byte(img[i], 1'b0);
    send_byte(8'h88, 1'b0);
    send_byte(CSUM_OK, 1'b0);
    wait_cycles(2);
    check_nominal("nom", base);

    // Checksum corruption
    apply_reset();
    base = wtot;
    for (int i = 0; i < 14; i++) send_byte(img[i], 1'b0);
    send_byte(8'h88, 1'b0);
    send_byte(8'h08, 1'b0);
    wait_cycles(2);
    chk("csum_nwr", 64'(wtot - base), 64'd2);
    chk("csum_d1", 64'(wd[(base + 1) % 64]), 64'h88776655);
    chk("csum_err", 64'(error), 64'd1);
    chk("csum_done", 64'(done), 64'd0);
    chk("csum_cpurst", 64'(cpu_reset), 64'd1);
    chk("csum_rdy", 64'(rx_ready), 64'd0);

    // Garbage prefix
    apply_reset();
    base = wtot;
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h5A, 1'b0);
    for (int i = 0; i < 14; i++) send_byte(img[i], 1'b0);
    send_byte(8'h88, 1'b0);
    send_byte(CSUM_OK, 1'b0);
    wait_cycles(2);
    check_nominal("garb", base);

    // LEN = 0
    apply_reset();
    base = wtot;
    send_byte(8'hA5, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    check_reject("len0", base);

    // LEN = 0x0401
    apply_reset();
    base = wtot;
    send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h04, 1'b0);
    check_reject("len401", base);

    // ENTRY = N rejected
    apply_reset();
    base = wtot;
    send_byte(8'hA5, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    check_reject("entry", base);

    // Random stalls
    apply_reset();
    base = wtot;
    for (int i = 0; i < 14; i++) send_byte(img[i], 1'b1);
    send_byte(8'h88, 1'b1);
    send_byte(CSUM_OK, 1'b1);
    wait_cycles(2);
    check_nominal("stall", base);

    // Reset mid-DATA after 5 data bytes, then a clean image
    apply_reset();
    for (int i = 0; i < 12; i++) send_byte(img[i], 1'b0);
    apply_reset();
    chk("mid_done", 64'(done), 64'd0);
    base = wtot;
    for (int i = 0; i < 14; i++) send_byte(img[i], 1'b0);
    send_byte(8'h88, 1'b0);
    send_byte(CSUM_OK, 1'b0);
    wait_cycles(2);
    check_nominal("mid", base);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
